// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Purpose  : VGA horizontal/vertical scan timing. Produces the pixel position,
//            the active-video qualifier, hsync/vsync and a frame-start pulse,
//            all registered and aligned to the same pixel.
// Options  : VGA_TIMING_FRAME_CNT_EN adds parameter FW and output o_frame_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
`ifdef VGA_TIMING_FRAME_CNT_EN
  , parameter int unsigned FW     = 8
`endif
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst_n,
  input  logic                                            i_en,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]    o_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]    o_y,
  output logic                                            o_active,
  output logic                                            o_hsync,
  output logic                                            o_vsync,
  output logic                                            o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  , output logic [FW-1:0]                                 o_frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = $clog2(H_TOTAL);
  localparam int unsigned YW      = $clog2(V_TOTAL);

  // Last pixel/line of each region; the FSMs move on when the count hits these.
  localparam logic [XW-1:0] X_ACT_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] X_FP_LAST   = XW'(H_ACTIVE + H_FP - 1);
  localparam logic [XW-1:0] X_SYNC_LAST = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [XW-1:0] X_LAST      = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] Y_FP_LAST   = YW'(V_ACTIVE + V_FP - 1);
  localparam logic [YW-1:0] Y_SYNC_LAST = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(V_TOTAL - 1);

  localparam logic [1:0] HS_ACT  = 2'd0;
  localparam logic [1:0] HS_FP   = 2'd1;
  localparam logic [1:0] HS_SYNC = 2'd2;
  localparam logic [1:0] HS_BP   = 2'd3;
  localparam logic [1:0] VS_ACT  = 2'd0;
  localparam logic [1:0] VS_FP   = 2'd1;
  localparam logic [1:0] VS_SYNC = 2'd2;
  localparam logic [1:0] VS_BP   = 2'd3;

  logic          running_q, running_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    hst_q, hst_d;
  logic [1:0]    vst_q, vst_d;
  logic          active_q, active_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          fstart_q, fstart_d;
  logic          x_wrap, y_wrap;

  // Scan position and H/V region FSMs; enable low discards the position.
  always_comb begin
    running_d = running_q;
    x_d       = x_q;
    y_d       = y_q;
    hst_d     = hst_q;
    vst_d     = vst_q;
    x_wrap    = 1'b0;
    y_wrap    = 1'b0;
    if (!i_en) begin
      running_d = 1'b0;
      x_d       = '0;
      y_d       = '0;
      hst_d     = HS_ACT;
      vst_d     = VS_ACT;
    end else if (!running_q) begin
      // First enabled edge shows pixel (0,0) straight away.
      running_d = 1'b1;
      x_d       = '0;
      y_d       = '0;
      hst_d     = HS_ACT;
      vst_d     = VS_ACT;
    end else begin
      x_wrap = (x_q == X_LAST);
      x_d    = x_wrap ? '0 : x_q + XW'(1);
      case (hst_q)
        HS_ACT:  if (x_q == X_ACT_LAST)  hst_d = HS_FP;
        HS_FP:   if (x_q == X_FP_LAST)   hst_d = HS_SYNC;
        HS_SYNC: if (x_q == X_SYNC_LAST) hst_d = HS_BP;
        HS_BP:   if (x_wrap)             hst_d = HS_ACT;
        default: hst_d = HS_ACT;
      endcase
      if (x_wrap) begin
        y_wrap = (y_q == Y_LAST);
        y_d    = y_wrap ? '0 : y_q + YW'(1);
        case (vst_q)
          VS_ACT:  if (y_q == Y_ACT_LAST)  vst_d = VS_FP;
          VS_FP:   if (y_q == Y_FP_LAST)   vst_d = VS_SYNC;
          VS_SYNC: if (y_q == Y_SYNC_LAST) vst_d = VS_BP;
          VS_BP:   if (y_wrap)             vst_d = VS_ACT;
          default: vst_d = VS_ACT;
        endcase
      end
    end
  end

  // Output decode from the next state so outputs line up with o_x/o_y.
  always_comb begin
    active_d = running_d && (hst_d == HS_ACT) && (vst_d == VS_ACT);
    hsync_d  = (running_d && (hst_d == HS_SYNC)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = (running_d && (vst_d == VS_SYNC)) ? SYNC_POL : ~SYNC_POL;
    fstart_d = running_d && (x_d == '0) && (y_d == '0);
  end

  // State and output registers; reset forces the idle picture at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      running_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      hst_q     <= HS_ACT;
      vst_q     <= VS_ACT;
      active_q  <= 1'b0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      fstart_q  <= 1'b0;
    end else begin
      running_q <= running_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hst_q     <= hst_d;
      vst_q     <= vst_d;
      active_q  <= active_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      fstart_q  <= fstart_d;
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_active      = active_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_frame_start = fstart_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Frame counter: bumps on each y wrap, holds while disabled.
  always_comb begin
    fcnt_d = fcnt_q;
    if (y_wrap) fcnt_d = fcnt_q + FW'(1);
  end

  // Frame counter register; only reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fcnt_q <= '0;
    else          fcnt_q <= fcnt_d;
  end

  assign o_frame_cnt = fcnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Purpose  : Self-checking bench for vga_timing_ctrl. Three instances (default
//            640x480 timing, a mid-size timing, a tiny active-high timing) share
//            clock, reset and enable; every cycle each is compared with a
//            position model derived from the elapsed pixel count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference state: running flag, pixels elapsed since (0,0), frames seen.
  bit run = 1'b0;
  int t   = 0;
  int fc[3];
  localparam int FL[3] = '{800*525, 23*17, 8*6};
  localparam int FM[3] = '{256, 256, 4};

  logic [9:0] d_x, d_y;
  logic       d_act, d_hs, d_vs, d_fs;
  logic [4:0] m_x, m_y;
  logic       m_act, m_hs, m_vs, m_fs;
  logic [2:0] s_x, s_y;
  logic       s_act, s_hs, s_vs, s_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] d_fc, m_fc;
  logic [1:0] s_fc;
`endif

  always #5 clk = ~clk;

  vga_timing_ctrl u_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_x(d_x), .o_y(d_y), .o_active(d_act), .o_hsync(d_hs), .o_vsync(d_vs),
    .o_frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(d_fc)
`endif
  );

  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_mid (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_x(m_x), .o_y(m_y), .o_active(m_act), .o_hsync(m_hs), .o_vsync(m_vs),
    .o_frame_start(m_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(m_fc)
`endif
  );

  vga_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .FW(2)
`endif
  ) u_sml (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_x(s_x), .o_y(s_y), .o_active(s_act), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(s_fc)
`endif
  );

  // Expected {x, y, active, hsync, vsync, frame_start} after t pixels.
  function automatic logic [35:0] model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                        input bit pol, input bit r, input int tt);
    int  ht, vt, x, y;
    bit  a, h, v, f;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (!r) return {16'd0, 16'd0, 1'b0, ~pol, ~pol, 1'b0};
    x = tt % ht;
    y = (tt / ht) % vt;
    a = (x < ha) && (y < va);
    h = (x >= ha + hf && x < ha + hf + hs) ? pol : ~pol;
    v = (y >= va + vf && y < va + vf + vs) ? pol : ~pol;
    f = (x == 0) && (y == 0);
    return {16'(x), 16'(y), a, h, v, f};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0d run=%0d)", tag, got, exp, t, run);
    end
  endtask

  task automatic check_all();
    chk("def", 64'({16'(d_x), 16'(d_y), d_act, d_hs, d_vs, d_fs}),
        64'(model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, run, t)));
    chk("mid", 64'({16'(m_x), 16'(m_y), m_act, m_hs, m_vs, m_fs}),
        64'(model(16, 2, 3, 2, 10, 2, 2, 3, 1'b0, run, t)));
    chk("sml", 64'({16'(s_x), 16'(s_y), s_act, s_hs, s_vs, s_fs}),
        64'(model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, run, t)));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("def_fcnt", 64'(d_fc), 64'(fc[0] % FM[0]));
    chk("mid_fcnt", 64'(m_fc), 64'(fc[1] % FM[1]));
    chk("sml_fcnt", 64'(s_fc), 64'(fc[2] % FM[2]));
`endif
  endtask

  // One clock edge: advance the reference, then check just after the edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (!en) begin
        run = 1'b0;
        t   = 0;
      end else if (!run) begin
        run = 1'b1;
        t   = 0;
      end else begin
        t++;
        for (int i = 0; i < 3; i++) if (t % FL[i] == 0) fc[i]++;
      end
    end
    #1 check_all();
  endtask

  initial begin
    fc = '{0, 0, 0};
    rst_n = 1'b0;
    en    = 1'b1;
    // Held in reset with enable high: idle outputs.
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;
    // Two full default lines plus a bit; many mid/small frames.
    repeat (1900) step();
    // Directed drop at default x=300 of line 2, hold low 5 cycles, restart.
    en = 1'b1;
    while (run && (t % 800) != 299) step();
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    repeat (400) step();
    // Randomised enable bursts and short gaps.
    for (int k = 0; k < 20; k++) begin
      en = 1'b1;
      repeat ($urandom_range(1, 700)) step();
      en = 1'b0;
      repeat ($urandom_range(1, 6)) step();
    end
    en = 1'b1;
    repeat (437) step();
    // Asynchronous reset between clock edges, mid-line.
    #2 rst_n = 1'b0;
    #1 begin
      run = 1'b0;
      t   = 0;
      fc  = '{0, 0, 0};
    end
    check_all();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (300) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
